// File: rtl/truth_table_checker_if.sv
// Bus between truth_table_checker and the testbench/system that owns the device under check.
//   slave  : checker side (receives start/expected/dut_out, drives vector and results)
//   master : controller side (drives start/expected/dut_out, observes vector and results)
// Parameters: N_IN device inputs, N_OUT device outputs.
interface truth_table_checker_if #(
    parameter int unsigned N_IN  = 3,
    parameter int unsigned N_OUT = 2
);
    localparam int unsigned NVEC   = 1 << N_IN;
    localparam int unsigned MASK_W = N_OUT * NVEC;

    logic                start_i;
    logic [MASK_W-1:0]   expected_i;
    logic [N_OUT-1:0]    dut_out_i;
    logic [N_IN-1:0]     vec_o;
    logic                busy_o;
    logic                done_o;
    logic                pass_o;
    logic [N_IN:0]       fail_cnt_o;
    logic [N_IN-1:0]     first_fail_vec_o;
    logic                first_fail_valid_o;
    logic [N_OUT-1:0]    fail_mask_o;

    modport slave (
        input  start_i, expected_i, dut_out_i,
        output vec_o, busy_o, done_o, pass_o, fail_cnt_o,
               first_fail_vec_o, first_fail_valid_o, fail_mask_o
    );

    modport master (
        output start_i, expected_i, dut_out_i,
        input  vec_o, busy_o, done_o, pass_o, fail_cnt_o,
               first_fail_vec_o, first_fail_valid_o, fail_mask_o
    );
endinterface

// File: rtl/truth_table_checker.sv
// Exhaustive truth-table sweep engine: drives every input vector 0..2^N_IN-1 into a
// combinational device, holds each for SETTLE cycles, samples the device outputs at the
// end of the window and compares them with a per-output minterm mask captured at start.
// Reports failure count, first failing vector, sticky per-output failure mask and pass.
// Ports:
//   clk_i   : clock, rising edge
//   rst_n_i : synchronous active-low reset
//   bus     : truth_table_checker_if.slave (start/expected/dut_out in, vector/results out)
module truth_table_checker #(
    parameter int unsigned N_IN   = 3,
    parameter int unsigned N_OUT  = 2,
    parameter int unsigned SETTLE = 4
) (
    input  logic                  clk_i,
    input  logic                  rst_n_i,
    truth_table_checker_if.slave  bus
);
    localparam int unsigned NVEC  = 1 << N_IN;
    localparam int unsigned FC_W  = N_IN + 1;
    localparam int unsigned SET_W = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SWEEP = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t                         state_q;
    logic [N_OUT-1:0][NVEC-1:0]     exp_q;
    logic [N_IN-1:0]                vec_q;
    logic [SET_W-1:0]               settle_q;
    logic                           busy_q;
    logic                           done_q;
    logic                           pass_q;
    logic [FC_W-1:0]                fail_cnt_q;
    logic [N_IN-1:0]                ff_vec_q;
    logic                           ff_valid_q;
    logic [N_OUT-1:0]               fail_mask_q;

    logic [N_OUT-1:0]               mis_c;
    logic                           any_mis_c;
    logic [FC_W-1:0]                fail_cnt_d;
    logic [N_OUT-1:0]               fail_mask_d;

    // Per-output mismatch of the current vector against the captured mask
    always_comb begin
        mis_c = '0;
        for (int k = 0; k < N_OUT; k++) begin
            mis_c[k] = bus.dut_out_i[k] ^ exp_q[k][vec_q];
        end
        any_mis_c   = |mis_c;
        fail_cnt_d  = fail_cnt_q + FC_W'(any_mis_c);
        fail_mask_d = fail_mask_q | mis_c;
    end

    // Sweep FSM with registered outputs
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_q     <= IDLE;
            exp_q       <= '0;
            vec_q       <= '0;
            settle_q    <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            pass_q      <= 1'b0;
            fail_cnt_q  <= '0;
            ff_vec_q    <= '0;
            ff_valid_q  <= 1'b0;
            fail_mask_q <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (bus.start_i) begin
                        state_q     <= SWEEP;
                        exp_q       <= bus.expected_i;
                        vec_q       <= '0;
                        // counter reaches zero on the edge that ends the window
                        settle_q    <= SET_W'(SETTLE - 1);
                        busy_q      <= 1'b1;
                        pass_q      <= 1'b0;
                        fail_cnt_q  <= '0;
                        ff_vec_q    <= '0;
                        ff_valid_q  <= 1'b0;
                        fail_mask_q <= '0;
                    end
                end
                SWEEP: begin
                    if (settle_q != '0) begin
                        settle_q <= settle_q - SET_W'(1);
                    end else begin
                        fail_cnt_q  <= fail_cnt_d;
                        fail_mask_q <= fail_mask_d;
                        if (any_mis_c && !ff_valid_q) begin
                            ff_vec_q   <= vec_q;
                            ff_valid_q <= 1'b1;
                        end
                        settle_q <= SET_W'(SETTLE - 1);
                        if (vec_q == N_IN'(NVEC - 1)) begin
                            state_q <= DONE;
                            vec_q   <= '0;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                            pass_q  <= (fail_cnt_d == '0);
                        end else begin
                            vec_q <= vec_q + N_IN'(1);
                        end
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus.vec_o              = vec_q;
    assign bus.busy_o             = busy_q;
    assign bus.done_o             = done_q;
    assign bus.pass_o             = pass_q;
    assign bus.fail_cnt_o         = fail_cnt_q;
    assign bus.first_fail_vec_o   = ff_vec_q;
    assign bus.first_fail_valid_o = ff_valid_q;
    assign bus.fail_mask_o        = fail_mask_q;
endmodule

// File: tb/tb_truth_table_checker.sv
// Directed bench for truth_table_checker: default 3-in/2-out instance driven by a
// configurable model of F1=XZ+YZ', F2=XY'+YZ', plus a 1-in/1-out SETTLE=1 instance on NOT.
module tb_truth_table_checker;
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    truth_table_checker_if #(.N_IN(3), .N_OUT(2)) bus_a ();
    truth_table_checker_if #(.N_IN(1), .N_OUT(1)) bus_b ();

    truth_table_checker #(.N_IN(3), .N_OUT(2), .SETTLE(4)) u_a (
        .clk_i   (clk),
        .rst_n_i (rst_n),
        .bus     (bus_a)
    );

    truth_table_checker #(.N_IN(1), .N_OUT(1), .SETTLE(1)) u_b (
        .clk_i   (clk),
        .rst_n_i (rst_n),
        .bus     (bus_b)
    );

    int checks = 0;
    int errors = 0;
    int mode   = 0;   // 0 correct, 1 F1 stuck-0, 2 F1 inverted and F2 stuck-1

    logic x, y, z, f1, f2;
    always_comb begin
        x  = bus_a.vec_o[2];
        y  = bus_a.vec_o[1];
        z  = bus_a.vec_o[0];
        f1 = (x & z) | (y & ~z);
        f2 = (x & ~y) | (y & ~z);
        case (mode)
            1:       bus_a.dut_out_i = {f2, 1'b0};
            2:       bus_a.dut_out_i = {1'b1, ~f1};
            default: bus_a.dut_out_i = {f2, f1};
        endcase
        bus_b.dut_out_i = ~bus_b.vec_o;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Accept a run on instance A and wait for done_o; returns cycles from acceptance
    task automatic run_a(input bit chk_vec, output int lat);
        lat = 0;
        bus_a.start_i = 1'b1;
        tick();
        bus_a.start_i = 1'b0;
        chk("a_busy_at_start", 32'(bus_a.busy_o), 32'd1);
        chk("a_vec_at_start", 32'(bus_a.vec_o), 32'd0);
        for (int c = 1; c <= 100; c++) begin
            tick();
            if (chk_vec && c < 32) chk("a_vec_step", 32'(bus_a.vec_o), 32'(c / 4));
            if (bus_a.done_o) begin
                lat = c;
                break;
            end
        end
        chk("a_latency", 32'(lat), 32'd32);
        chk("a_busy_done", 32'(bus_a.busy_o), 32'd0);
        chk("a_vec_done", 32'(bus_a.vec_o), 32'd0);
    endtask

    int lat;
    int done_seen;

    initial begin
        rst_n            = 1'b0;
        bus_a.start_i    = 1'b0;
        bus_a.expected_i = 16'h74E4;
        bus_b.start_i    = 1'b0;
        bus_b.expected_i = 2'b01;
        tick();
        tick();
        rst_n = 1'b1;

        // Reset state
        chk("rst_vec", 32'(bus_a.vec_o), 32'd0);
        chk("rst_busy", 32'(bus_a.busy_o), 32'd0);
        chk("rst_done", 32'(bus_a.done_o), 32'd0);
        chk("rst_pass", 32'(bus_a.pass_o), 32'd0);
        chk("rst_cnt", 32'(bus_a.fail_cnt_o), 32'd0);
        chk("rst_ffvalid", 32'(bus_a.first_fail_valid_o), 32'd0);
        chk("rst_mask", 32'(bus_a.fail_mask_o), 32'd0);
        tick();

        // Correct device
        mode = 0;
        run_a(1'b1, lat);
        chk("good_pass", 32'(bus_a.pass_o), 32'd1);
        chk("good_cnt", 32'(bus_a.fail_cnt_o), 32'd0);
        chk("good_mask", 32'(bus_a.fail_mask_o), 32'd0);
        chk("good_ffvalid", 32'(bus_a.first_fail_valid_o), 32'd0);
        tick();
        chk("good_done_pulse", 32'(bus_a.done_o), 32'd0);
        chk("good_pass_hold", 32'(bus_a.pass_o), 32'd1);

        // F1 stuck at 0
        mode = 1;
        run_a(1'b0, lat);
        chk("sa0_cnt", 32'(bus_a.fail_cnt_o), 32'd4);
        chk("sa0_ffvec", 32'(bus_a.first_fail_vec_o), 32'd2);
        chk("sa0_ffvalid", 32'(bus_a.first_fail_valid_o), 32'd1);
        chk("sa0_mask", 32'(bus_a.fail_mask_o), 32'd1);
        chk("sa0_pass", 32'(bus_a.pass_o), 32'd0);
        tick();

        // All vectors fail
        mode = 2;
        run_a(1'b0, lat);
        chk("all_cnt", 32'(bus_a.fail_cnt_o), 32'd8);
        chk("all_ffvec", 32'(bus_a.first_fail_vec_o), 32'd0);
        chk("all_mask", 32'(bus_a.fail_mask_o), 32'd3);
        chk("all_pass", 32'(bus_a.pass_o), 32'd0);
        tick();

        // Reset mid-run at cycle 13 (vectors 0..2 sampled, vector 2 failing)
        mode = 1;
        bus_a.start_i = 1'b1;
        tick();
        bus_a.start_i = 1'b0;
        for (int c = 1; c <= 12; c++) tick();
        chk("mid_cnt_before", 32'(bus_a.fail_cnt_o), 32'd1);
        chk("mid_vec_before", 32'(bus_a.vec_o), 32'd3);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("mid_rst_vec", 32'(bus_a.vec_o), 32'd0);
        chk("mid_rst_busy", 32'(bus_a.busy_o), 32'd0);
        chk("mid_rst_cnt", 32'(bus_a.fail_cnt_o), 32'd0);
        chk("mid_rst_ffvalid", 32'(bus_a.first_fail_valid_o), 32'd0);
        chk("mid_rst_mask", 32'(bus_a.fail_mask_o), 32'd0);
        done_seen = 0;
        for (int c = 0; c < 40; c++) begin
            tick();
            if (bus_a.done_o) done_seen++;
        end
        chk("mid_no_done", 32'(done_seen), 32'd0);
        mode = 0;
        run_a(1'b0, lat);
        chk("mid_rerun_pass", 32'(bus_a.pass_o), 32'd1);
        tick();

        // start_i held 40 cycles, expected_i altered mid-run
        bus_a.expected_i = 16'h74E4;
        bus_a.start_i    = 1'b1;
        tick();
        done_seen = 0;
        for (int c = 1; c <= 39; c++) begin
            if (c == 16) bus_a.expected_i = 16'h0000;
            tick();
            if (bus_a.done_o) begin
                done_seen++;
                chk("hold_done_cycle", 32'(c), 32'd32);
                chk("hold_first_pass", 32'(bus_a.pass_o), 32'd1);
            end
            if (c == 33) chk("hold_idle_gap", 32'(bus_a.busy_o), 32'd0);
            if (c == 34) chk("hold_restart", 32'(bus_a.busy_o), 32'd1);
        end
        bus_a.start_i = 1'b0;
        chk("hold_one_done", 32'(done_seen), 32'd1);
        lat = 0;
        for (int c = 40; c <= 140; c++) begin
            tick();
            if (bus_a.done_o) begin
                lat = c;
                break;
            end
        end
        chk("hold_second_lat", 32'(lat), 32'd66);
        chk("hold_second_cnt", 32'(bus_a.fail_cnt_o), 32'd5);
        chk("hold_second_ffvec", 32'(bus_a.first_fail_vec_o), 32'd2);
        chk("hold_second_mask", 32'(bus_a.fail_mask_o), 32'd3);
        tick();

        // Minimal configuration: NOT gate, SETTLE=1
        bus_b.start_i = 1'b1;
        tick();
        bus_b.start_i = 1'b0;
        lat = 0;
        for (int c = 1; c <= 20; c++) begin
            tick();
            if (bus_b.done_o) begin
                lat = c;
                break;
            end
        end
        chk("b_latency", 32'(lat), 32'd2);
        chk("b_pass", 32'(bus_b.pass_o), 32'd1);
        chk("b_cnt", 32'(bus_b.fail_cnt_o), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
